// File: rtl/ak16_pipe_pkg.sv
// Shared types and constants for the Ak-16b pipeline control blocks.
package ak16_pipe_pkg;

   localparam int unsigned REG_ADDR_W = 4;
   localparam int unsigned DATA_W     = 16;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {
      StRun,
      StMemWait,
      StDrain,
      StHalted
   } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master = controller side, slave = datapath side.
interface pipe_hazard_ctrl_if;
   import ak16_pipe_pkg::*;

   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_use_rs1;
   logic                  id_use_rs2;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_mem_read;
   logic                  ex_branch_taken;
   logic                  mem_req;
   logic                  mem_ready;
   logic                  halt_req;

   logic                  stall_if;
   logic                  stall_id;
   logic                  stall_ex;
   logic                  flush_id;
   logic                  flush_ex;
   logic                  flush_wb;
   logic                  halted;
   logic                  mem_err;
   logic [15:0]           stall_cycles;

   modport master (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
      input  ex_branch_taken, mem_req, mem_ready, halt_req,
      output stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_wb,
      output halted, mem_err, stall_cycles
   );

   modport slave (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
      output ex_branch_taken, mem_req, mem_ready, halt_req,
      input  stall_if, stall_id, stall_ex, flush_id, flush_ex, flush_wb,
      input  halted, mem_err, stall_cycles
   );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
   import ak16_pipe_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   output logic                  load_use
);

   logic hit_rs1;
   logic hit_rs2;

   assign hit_rs1  = id_use_rs1 && (id_rs1 == ex_rd);
   assign hit_rs2  = id_use_rs2 && (id_rs2 == ex_rd);
   // r0 is hard-wired zero, so a load targeting it never creates a dependency
   assign load_use = ex_mem_read && (ex_rd != REG_ZERO) && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the Ak-16b pipeline: load-use, branch, memory wait, halt drain.
// Define STALL_STATS_EN to build the saturating stall_cycles counter.
module pipe_hazard_ctrl
   import ak16_pipe_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 3,
   parameter int unsigned MEM_TIMEOUT  = 15
) (
   input logic                clk,
   input logic                rst_n,
   pipe_hazard_ctrl_if.master hz
);

   localparam int unsigned WaitW  = $clog2(MEM_TIMEOUT + 1);
   localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [WaitW-1:0]  WaitMax   = WaitW'(MEM_TIMEOUT);
   localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

   hz_state_e         state_q, state_d;
   logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
   logic [DrainW-1:0] drain_cnt_q, drain_cnt_d;
   logic              ret_drain_q, ret_drain_d;
   logic              mem_err_q, mem_err_d;

   logic load_use;
   logic mem_stall;
   logic s_if, s_id, s_ex, f_id, f_ex, f_wb;

   load_use_detect u_load_use_detect (
      .id_rs1      (hz.id_rs1),
      .id_rs2      (hz.id_rs2),
      .id_use_rs1  (hz.id_use_rs1),
      .id_use_rs2  (hz.id_use_rs2),
      .ex_rd       (hz.ex_rd),
      .ex_mem_read (hz.ex_mem_read),
      .load_use    (load_use)
   );

   assign mem_stall = hz.mem_req && !hz.mem_ready;

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      drain_cnt_d = drain_cnt_q;
      ret_drain_d = ret_drain_q;
      mem_err_d   = mem_err_q;
      s_if = 1'b0;
      s_id = 1'b0;
      s_ex = 1'b0;
      f_id = 1'b0;
      f_ex = 1'b0;
      f_wb = 1'b0;

      unique case (state_q)
         StRun: begin
            if (mem_stall) begin
               {s_if, s_id, s_ex, f_wb} = 4'b1111;
               state_d     = StMemWait;
               wait_cnt_d  = '0;
               ret_drain_d = 1'b0;
            end else if (hz.ex_branch_taken) begin
               {f_id, f_ex} = 2'b11;
            end else if (load_use) begin
               {s_if, s_id, f_ex} = 3'b111;
            end else if (hz.halt_req) begin
               {s_if, f_id} = 2'b11;
               state_d      = StDrain;
               drain_cnt_d  = '0;
            end
         end

         StMemWait: begin
            if (hz.mem_ready) begin
               wait_cnt_d = '0;
               if (ret_drain_q) begin
                  state_d      = StDrain;
                  {s_if, f_id} = 2'b11;
                  f_ex         = hz.ex_branch_taken;
               end else begin
                  state_d = StRun;
                  // EX was frozen through the wait, so its branch/load-use acts now
                  if (hz.ex_branch_taken) begin
                     {f_id, f_ex} = 2'b11;
                  end else if (load_use) begin
                     {s_if, s_id, f_ex} = 3'b111;
                  end
               end
            end else if (wait_cnt_q == WaitMax) begin
               mem_err_d          = 1'b1;
               {f_id, f_ex, f_wb} = 3'b111;
               wait_cnt_d         = '0;
               state_d            = ret_drain_q ? StDrain : StRun;
            end else begin
               {s_if, s_id, s_ex, f_wb} = 4'b1111;
               wait_cnt_d               = wait_cnt_q + WaitW'(1);
            end
         end

         StDrain: begin
            if (mem_stall) begin
               // Pure memory stall: the ID instruction must survive to drain later
               {s_if, s_id, s_ex, f_wb} = 4'b1111;
               state_d     = StMemWait;
               wait_cnt_d  = '0;
               ret_drain_d = 1'b1;
            end else begin
               {s_if, f_id} = 2'b11;
               f_ex         = hz.ex_branch_taken;
               if (drain_cnt_q == DrainLast) begin
                  state_d = StHalted;
               end else begin
                  drain_cnt_d = drain_cnt_q + DrainW'(1);
               end
            end
         end

         StHalted: begin
            {s_if, f_id} = 2'b11;
            if (!hz.halt_req) begin
               state_d = StRun;
            end
         end
      endcase

      // Controls are combinational from inputs, so hold them quiet while in reset
      if (!rst_n) begin
         {s_if, s_id, s_ex, f_id, f_ex, f_wb} = 6'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StRun;
         wait_cnt_q  <= '0;
         drain_cnt_q <= '0;
         ret_drain_q <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         ret_drain_q <= ret_drain_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign hz.stall_if = s_if;
   assign hz.stall_id = s_id;
   assign hz.stall_ex = s_ex;
   assign hz.flush_id = f_id;
   assign hz.flush_ex = f_ex;
   assign hz.flush_wb = f_wb;
   assign hz.halted   = (state_q == StHalted);
   assign hz.mem_err  = mem_err_q;

`ifdef STALL_STATS_EN
   logic [15:0] stall_cycles_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
      end else if (s_if && (state_q != StHalted) && (stall_cycles_q != 16'hFFFF)) begin
         stall_cycles_q <= stall_cycles_q + 16'd1;
      end
   end

   assign hz.stall_cycles = stall_cycles_q;
`else
   assign hz.stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl.
// Output vector order: stall_if stall_id stall_ex flush_id flush_ex flush_wb halted mem_err.
module tb_pipe_hazard_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   errors = 0;
   int   checks = 0;

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(
      .DRAIN_CYCLES (3),
      .MEM_TIMEOUT  (15)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {hz.stall_if, hz.stall_id, hz.stall_ex, hz.flush_id,
              hz.flush_ex, hz.flush_wb, hz.halted, hz.mem_err};
   endfunction

   task automatic idle();
      hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_use_rs1 = 1'b0; hz.id_use_rs2 = 1'b0;
      hz.ex_rd = '0; hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0;
      hz.mem_req = 1'b0; hz.mem_ready = 1'b0; hz.halt_req = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lu(input logic [3:0] rd);
      hz.ex_mem_read = 1'b1; hz.ex_rd = rd;
      hz.id_rs1 = 4'd5; hz.id_use_rs1 = 1'b1;
      hz.id_rs2 = 4'd3; hz.id_use_rs2 = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      #1 rst_n = 1'b0;
      #2;
      checks++;
      if (outs() !== 8'b0) begin errors++; $display("FAIL reset_outs: got %b want %b", outs(), 8'b0); end
      checks++;
      if (hz.stall_cycles !== 16'd0) begin
         errors++; $display("FAIL reset_stats: got %0d want 0", hz.stall_cycles);
      end
      @(negedge clk) rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load_use();
      set_lu(4'd3);
      hz.id_use_rs1 = 1'b0;
      @(negedge clk); checks++;
      if (outs() !== 8'b1100_1000) begin errors++; $display("FAIL lu_rs2: got %b want %b", outs(), 8'b1100_1000); end
      tick();
      hz.ex_mem_read = 1'b0;  // bubble now in EX
      @(negedge clk); checks++;
      if (outs() !== 8'b0) begin errors++; $display("FAIL lu_one_bubble: got %b want %b", outs(), 8'b0); end
      tick();
      set_lu(4'd0);
      @(negedge clk); checks++;
      if (outs() !== 8'b0) begin errors++; $display("FAIL lu_r0: got %b want %b", outs(), 8'b0); end
      tick();
      set_lu(4'd5);
      hz.id_use_rs2 = 1'b0;
      @(negedge clk); checks++;
      if (outs() !== 8'b1100_1000) begin errors++; $display("FAIL lu_rs1: got %b want %b", outs(), 8'b1100_1000); end
      tick();
      hz.id_use_rs1 = 1'b0;
      @(negedge clk); checks++;
      if (outs() !== 8'b0) begin errors++; $display("FAIL lu_unused_src: got %b want %b", outs(), 8'b0); end
      tick();
      idle();
   endtask

   task automatic test_branch();
      set_lu(4'd3);
      hz.ex_branch_taken = 1'b1;
      @(negedge clk); checks++;
      if (outs() !== 8'b0001_1000) begin errors++; $display("FAIL branch_over_lu: got %b want %b", outs(), 8'b0001_1000); end
      tick();
      idle();
      hz.ex_branch_taken = 1'b1;
      @(negedge clk); checks++;
      if (outs() !== 8'b0001_1000) begin errors++; $display("FAIL branch_only: got %b want %b", outs(), 8'b0001_1000); end
      tick();
      idle();
   endtask

   task automatic test_mem_wait();
      hz.mem_req = 1'b1; hz.ex_branch_taken = 1'b1; set_lu(4'd3);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); checks++;
         if (outs() !== 8'b1110_0100) begin
            errors++; $display("FAIL mem_wait_stall[%0d]: got %b want %b", i, outs(), 8'b1110_0100);
         end
         tick();
         if (i == 0) begin idle(); hz.mem_req = 1'b1; end
      end
      hz.mem_ready = 1'b1;
      @(negedge clk); checks++;
      if (outs() !== 8'b0) begin errors++; $display("FAIL mem_wait_release: got %b want %b", outs(), 8'b0); end
      tick();
      idle();
      @(negedge clk); checks++;
      if (outs() !== 8'b0) begin errors++; $display("FAIL mem_wait_after: got %b want %b", outs(), 8'b0); end
      tick();
   endtask

   task automatic test_halt();
      hz.halt_req = 1'b1;
      @(negedge clk); checks++;
      if (outs() !== 8'b1001_0000) begin errors++; $display("FAIL halt_entry: got %b want %b", outs(), 8'b1001_0000); end
      tick();
      for (int i = 0; i < 3; i++) begin
         hz.ex_branch_taken = (i == 1);
         @(negedge clk); checks++;
         if (outs() !== ((i == 1) ? 8'b1001_1000 : 8'b1001_0000)) begin
            errors++; $display("FAIL halt_drain[%0d]: got %b want %b", i, outs(),
                               (i == 1) ? 8'b1001_1000 : 8'b1001_0000);
         end
         tick();
      end
      hz.ex_branch_taken = 1'b0;
      @(negedge clk); checks++;
      if (outs() !== 8'b1001_0010) begin errors++; $display("FAIL halted_set: got %b want %b", outs(), 8'b1001_0010); end
      tick();
      hz.halt_req = 1'b0;
      @(negedge clk); checks++;
      if (outs() !== 8'b1001_0010) begin errors++; $display("FAIL halted_hold: got %b want %b", outs(), 8'b1001_0010); end
      tick();
      @(negedge clk); checks++;
      if (outs() !== 8'b0) begin errors++; $display("FAIL halted_clear: got %b want %b", outs(), 8'b0); end
      tick();
   endtask

   task automatic test_halt_pulse();
      hz.halt_req = 1'b1;
      @(negedge clk); checks++;
      if (outs() !== 8'b1001_0000) begin errors++; $display("FAIL pulse_entry: got %b want %b", outs(), 8'b1001_0000); end
      tick();
      hz.halt_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); checks++;
         if (outs() !== 8'b1001_0000) begin
            errors++; $display("FAIL pulse_drain[%0d]: got %b want %b", i, outs(), 8'b1001_0000);
         end
         tick();
      end
      @(negedge clk); checks++;
      if (outs() !== 8'b1001_0010) begin errors++; $display("FAIL pulse_halted: got %b want %b", outs(), 8'b1001_0010); end
      tick();
      @(negedge clk); checks++;
      if (outs() !== 8'b0) begin errors++; $display("FAIL pulse_run: got %b want %b", outs(), 8'b0); end
      tick();
   endtask

   task automatic test_drain_mem_wait();
      hz.halt_req = 1'b1;
      tick();  // enter drain
      hz.mem_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); checks++;
         if (outs() !== 8'b1110_0100) begin
            errors++; $display("FAIL drain_mem_stall[%0d]: got %b want %b", i, outs(), 8'b1110_0100);
         end
         tick();
      end
      hz.mem_ready = 1'b1;
      @(negedge clk); checks++;
      if (outs() !== 8'b1001_0000) begin errors++; $display("FAIL drain_mem_release: got %b want %b", outs(), 8'b1001_0000); end
      tick();
      hz.mem_req = 1'b0; hz.mem_ready = 1'b0;
      // drain_cnt held through the wait, so three full drain cycles remain
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); checks++;
         if (outs() !== 8'b1001_0000) begin
            errors++; $display("FAIL drain_resume[%0d]: got %b want %b", i, outs(), 8'b1001_0000);
         end
         tick();
      end
      hz.halt_req = 1'b0;
      @(negedge clk); checks++;
      if (outs() !== 8'b1001_0010) begin errors++; $display("FAIL drain_mem_halted: got %b want %b", outs(), 8'b1001_0010); end
      tick();
      idle();
   endtask

   task automatic test_timeout();
      hz.mem_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk); checks++;
         if (outs() !== 8'b1110_0100) begin
            errors++; $display("FAIL timeout_stall[%0d]: got %b want %b", i, outs(), 8'b1110_0100);
         end
         tick();
      end
      @(negedge clk); checks++;
      if (outs() !== 8'b0001_1100) begin errors++; $display("FAIL timeout_abort: got %b want %b", outs(), 8'b0001_1100); end
      tick();
      hz.mem_req = 1'b0;
      @(negedge clk); checks++;
      if (outs() !== 8'b0000_0001) begin errors++; $display("FAIL timeout_err: got %b want %b", outs(), 8'b0000_0001); end
      tick();
      set_lu(4'd3);
      @(negedge clk); checks++;
      if (outs() !== 8'b1100_1001) begin errors++; $display("FAIL timeout_sticky: got %b want %b", outs(), 8'b1100_1001); end
      tick();
      idle();
   endtask

   task automatic test_reset_mid_wait();
      hz.mem_req = 1'b1;
      @(negedge clk); checks++;
      if (outs() !== 8'b1110_0101) begin errors++; $display("FAIL pre_reset_stall: got %b want %b", outs(), 8'b1110_0101); end
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1; checks++;
      if (outs() !== 8'b0) begin errors++; $display("FAIL reset_mid_outs: got %b want %b", outs(), 8'b0); end
      checks++;
      if (hz.stall_cycles !== 16'd0) begin
         errors++; $display("FAIL reset_mid_stats: got %0d want 0", hz.stall_cycles);
      end
      @(negedge clk);
      rst_n = 1'b1;
      hz.mem_req = 1'b0;
      tick();
      set_lu(4'd3);
      @(negedge clk); checks++;
      if (outs() !== 8'b1100_1000) begin errors++; $display("FAIL reset_mid_run: got %b want %b", outs(), 8'b1100_1000); end
      tick();
      idle();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_halt();
      test_halt_pulse();
      test_drain_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the Ak-16b 5-stage core. It generates every stall and flush control for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard types:
- load-use hazards
- taken-branch redirects from EX
- data-memory wait states
It also runs a halt/drain sequence, so the pipeline empties cleanly before the core stops.

Parameters:
REG_ADDR_W, 4, register-index width (16 GPRs)
DRAIN_CYCLES, 3, cycles needed to empty ID..WB after fetch stops
MEM_TIMEOUT, 15, maximum MEM_WAIT cycles before abort; counter width is clog2(MEM_TIMEOUT+1)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  REG_ADDR_W  source reg 1 of the instruction in ID
id_rs2  in  REG_ADDR_W  source reg 2 of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd  in  REG_ADDR_W  destination of the instruction in EX
ex_mem_read  in  1  instruction in EX is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump
mem_req  in  1  instruction in MEM accesses data memory
mem_ready  in  1  data memory completes access this cycle
halt_req  in  1  level request to halt the core
stall_if  out  1  hold PC and IF/ID
stall_id  out  1  hold ID/EX inputs (decode)
stall_ex  out  1  hold EX/MEM
flush_id  out  1  bubble into IF/ID
flush_ex  out  1  bubble into ID/EX
flush_wb  out  1  bubble into MEM/WB (drives MEM/WB flush_wb)
halted  out  1  core fully drained and stopped
mem_err  out  1  sticky: memory timeout occurred
stall_cycles  out  16  stall statistics counter (see Optional Feature)

Behaviour:
- Reset (rst_n=0, async): state=RUN; wait_cnt=0; drain_cnt=0; mem_err=0; halted=0; all stall/flush outputs=0; stall_cycles=0.
- States: RUN, MEM_WAIT, DRAIN, HALTED. Stall/flush outputs are combinational from state and inputs, so they take effect in the same cycle.
- Load-use condition LU: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)). Register 0 never hazards.
- RUN, priority highest to lowest:
  1. Memory stall: mem_req && !mem_ready. Assert stall_if, stall_id, stall_ex, flush_wb. Next state = MEM_WAIT. Branch and LU are ignored this cycle; EX is frozen, so they re-present later.
  2. Branch: ex_branch_taken. Assert flush_id and flush_ex. LU is suppressed.
  3. Load-use: LU. Assert stall_if, stall_id, flush_ex. This gives exactly 1 bubble.
  4. Halt: halt_req. Assert stall_if and flush_id. Next state = DRAIN with drain_cnt=0.
- MEM_WAIT:
  - Same 4 outputs as the memory stall. wait_cnt increments each cycle.
  - mem_ready=1: deassert all stalls that cycle; wait_cnt=0; next state = RUN.
  - wait_cnt==MEM_TIMEOUT && !mem_ready: set mem_err (sticky until reset). Assert flush_wb, flush_ex, flush_id for 1 cycle. wait_cnt=0; next state = RUN.
- DRAIN:
  - stall_if=1 and flush_id=1 every cycle; drain_cnt increments.
  - A memory wait inside DRAIN behaves as MEM_WAIT, but returns to DRAIN; drain_cnt holds meanwhile.
  - Branch flushes are still applied.
  - drain_cnt==DRAIN_CYCLES-1: next state = HALTED.
- HALTED:
  - halted=1, stall_if=1, flush_id=1.
  - halt_req falling: next state = RUN; halted drops on the following cycle.
- halt_req deasserted during DRAIN: the drain still completes; the block goes to HALTED, then immediately to RUN.
- rst_n asserted mid-operation: immediate return to reset values; no partial sequence resumes.

Optional Feature:
STALL_STATS_EN
- Defined: stall_cycles increments on every cycle where stall_if=1 and state!=HALTED. It saturates at 16'hFFFF and clears only on reset.
- Undefined: stall_cycles is tied to 16'd0 and no counter logic exists.

Decomposition:
- Package ak16_pipe_pkg holds:
  - hazard-controller state enum (RUN, MEM_WAIT, DRAIN, HALTED)
  - REG_ADDR_W and DATA_W=16 constants
  - REG_ZERO=4'd0
- One combinational sub-module, load_use_detect, computes LU from the id_* and ex_* inputs. pipe_hazard_ctrl keeps the FSM and counters.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rd=3, id_rs2=3, id_use_rs2=1 -> 1 cycle of stall_if=stall_id=flush_ex=1. Same stimulus with ex_rd=0 -> no stall.
2. Branch + load-use together: ex_branch_taken=1 with LU true -> flush_id=flush_ex=1, stall_if=0.
3. Memory wait: mem_req=1, mem_ready low for 4 cycles -> stall_if/id/ex and flush_wb high for 4 cycles; release in the cycle mem_ready=1; mem_err=0.
4. Timeout: mem_ready held low -> after MEM_TIMEOUT=15 wait cycles, mem_err=1 and a 1-cycle flush of id/ex/wb; state returns to RUN; mem_err stays 1.
5. Halt: pulse halt_req high -> halted=1 after DRAIN_CYCLES=3 cycles (plus entry cycle); drop halt_req -> halted=0 next cycle.
6. Reset: assert rst_n=0 mid-MEM_WAIT -> all outputs 0 asynchronously; after release, state=RUN. With STALL_STATS_EN defined, stall_cycles=0.
